// File: rtl/dsec_pkg.sv
// dsec_pkg: shared state encodings and parameter defaults for the DSEC control slice
package dsec_pkg;
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] BUSY  = 2'd2;
  localparam logic [1:0] HOLD  = 2'd3;
  localparam int DEF_NUM_KEY_WORDS = 3;
  localparam int DEF_KSEL_W        = 2;
  localparam int DEF_CORE_TIMEOUT  = 64;
endpackage

// File: rtl/dsec_if.sv
// dsec_if: handshake and strobe bundle between the DSEC controller and its datapath/host
//   slave  : controller side (takes key_config/in_valid/out_rcvd/core_done, drives the rest)
//   master : host/datapath side
interface dsec_if import dsec_pkg::*; #(
  parameter int KSEL_W = DEF_KSEL_W
) ();
  logic key_config;
  logic in_valid;
  logic out_rcvd;
  logic core_done;
  logic rdy;
  logic out_valid;
  logic error;
  logic key_we;
  logic [KSEL_W-1:0] key_sel;
  logic key_loaded;
  logic data_ld;
  logic core_start;
  logic out_ld;
  modport slave (
    input  key_config, in_valid, out_rcvd, core_done,
    output rdy, out_valid, error, key_we, key_sel, key_loaded, data_ld, core_start, out_ld
  );
  modport master (
    output key_config, in_valid, out_rcvd, core_done,
    input  rdy, out_valid, error, key_we, key_sel, key_loaded, data_ld, core_start, out_ld
  );
endinterface

// File: rtl/dsec_key_seq.sv
// dsec_key_seq: key word sequencer (key_cnt, key_we/key_sel strobes, key_loaded, partial-key detect)
//   idle        : controller is in IDLE; key words and the partial check only count there
//   key_we      : same-cycle write strobe for key word key_sel
//   key_loaded  : registered, set when the last word of a set is written
//   partial_err : key_config dropped with a set half written; one-cycle event
module dsec_key_seq import dsec_pkg::*; #(
  parameter int NUM_KEY_WORDS = DEF_NUM_KEY_WORDS,
  parameter int KSEL_W        = DEF_KSEL_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              idle,
  input  logic              key_config,
  input  logic              in_valid,
  output logic              key_we,
  output logic [KSEL_W-1:0] key_sel,
  output logic              key_loaded,
  output logic              partial_err
);
  logic [KSEL_W-1:0] key_cnt;
  logic last;
  assign key_sel = key_cnt;
  assign key_we = idle & key_config & in_valid;
  assign last = key_cnt == KSEL_W'(NUM_KEY_WORDS - 1);
  // key_cnt is only nonzero mid-set, so a low key_config in IDLE with key_cnt!=0 is the falling edge
  assign partial_err = idle & ~key_config & (key_cnt != '0);
  always_ff @(posedge clk)
    if (rst) begin
      key_cnt <= '0;
      key_loaded <= 1'b0;
    end else if (partial_err) begin
      key_cnt <= '0;
    end else if (key_we) begin
      key_cnt <= last ? '0 : key_cnt + KSEL_W'(1);
      key_loaded <= last;
    end
endmodule

// File: rtl/dsec_ctrl.sv
// dsec_ctrl: control FSM sequencing the DSEC cipher datapath (key load, start, wait, hold)
//   clk, rst : clock, synchronous active-high reset
//   bus      : dsec_if.slave handshake/strobe bundle
//   err_cnt  : saturating error event count, present only with DSEC_ERR_COUNT_EN defined
module dsec_ctrl import dsec_pkg::*; #(
  parameter int NUM_KEY_WORDS = DEF_NUM_KEY_WORDS,
  parameter int KSEL_W        = DEF_KSEL_W,
  parameter int CORE_TIMEOUT  = DEF_CORE_TIMEOUT
) (
  input  logic       clk,
  input  logic       rst,
`ifdef DSEC_ERR_COUNT_EN
  output logic [7:0] err_cnt,
`endif
  dsec_if.slave      bus
);
  localparam int TW = $clog2(CORE_TIMEOUT + 1);
  logic [1:0] state, state_nx;
  logic [TW-1:0] tcnt;
  logic idle, busy, hold, accept, drop, bad_iv, tmo, partial_err, key_loaded;
  dsec_key_seq #(.NUM_KEY_WORDS(NUM_KEY_WORDS), .KSEL_W(KSEL_W)) u_key_seq (
    .clk(clk),
    .rst(rst),
    .idle(idle),
    .key_config(bus.key_config),
    .in_valid(bus.in_valid),
    .key_we(bus.key_we),
    .key_sel(bus.key_sel),
    .key_loaded(key_loaded),
    .partial_err(partial_err)
  );
  assign idle = state == IDLE;
  assign busy = state == BUSY;
  assign hold = state == HOLD;
  assign accept = idle & bus.in_valid & ~bus.key_config & key_loaded;
  assign drop = idle & bus.in_valid & ~bus.key_config & ~key_loaded;
  assign bad_iv = ~idle & bus.in_valid;
  // core_done on the last allowed BUSY cycle still completes normally
  assign tmo = busy & ~bus.core_done & (tcnt == TW'(CORE_TIMEOUT - 1));
  assign bus.rdy = idle;
  assign bus.key_loaded = key_loaded;
  assign bus.data_ld = accept;
  assign bus.out_ld = busy & bus.core_done;
  always_comb
    state_nx = idle ? (accept ? START : IDLE) :
               (state == START) ? BUSY :
               busy ? (bus.core_done ? HOLD : (tmo ? IDLE : BUSY)) :
               (bus.out_rcvd ? IDLE : HOLD);
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      tcnt <= '0;
      bus.error <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.core_start <= 1'b0;
    end else begin
      state <= state_nx;
      tcnt <= (busy & ~bus.core_done & ~tmo) ? tcnt + TW'(1) : '0;
      bus.error <= bus.error | bad_iv | drop | tmo | partial_err;
      bus.out_valid <= (busy & bus.core_done) | (hold & ~bus.out_rcvd);
      bus.core_start <= accept;
    end
`ifdef DSEC_ERR_COUNT_EN
  logic [8:0] err_sum;
  assign err_sum = {1'b0, err_cnt} + 9'(bad_iv) + 9'(drop) + 9'(tmo) + 9'(partial_err);
  always_ff @(posedge clk)
    if (rst) err_cnt <= '0;
    else err_cnt <= err_sum[8] ? 8'hFF : err_sum[7:0];
`endif
endmodule

// File: tb/tb_dsec_ctrl.sv
// tb_dsec_ctrl: table-driven cycle vectors plus scoreboarded out_ld latency for dsec_ctrl
module tb_dsec_ctrl;
  import dsec_pkg::*;
  // in = {rst, key_config, in_valid, out_rcvd, core_done}
  // ex = {rdy, out_valid, error, key_we, key_sel[1:0], key_loaded, data_ld, core_start, out_ld}
  // lat = cycles from this row to the expected out_ld (0 = nothing queued)
  typedef struct {
    logic [4:0] in;
    logic [9:0] ex;
    int         lat;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int exp_q[$];
  vec_t tbl[30];
  logic [9:0] act;
  dsec_if #(.KSEL_W(2)) bus ();
`ifdef DSEC_ERR_COUNT_EN
  logic [7:0] err_cnt;
`endif
  dsec_ctrl #(.NUM_KEY_WORDS(3), .KSEL_W(2), .CORE_TIMEOUT(64)) dut (
    .clk(clk),
    .rst(rst),
`ifdef DSEC_ERR_COUNT_EN
    .err_cnt(err_cnt),
`endif
    .bus(bus.slave)
  );
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, a, e);
    end
  endtask

  task automatic step(input logic [4:0] in);
    @(posedge clk);
    #1;
    {rst, bus.key_config, bus.in_valid, bus.out_rcvd, bus.core_done} = in;
    #4;
    cyc++;
    act = {bus.rdy, bus.out_valid, bus.error, bus.key_we, bus.key_sel,
           bus.key_loaded, bus.data_ld, bus.core_start, bus.out_ld};
    if (bus.out_ld === 1'b1) begin
      chk("ld_pending", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) chk("ld_cycle", cyc, exp_q.pop_front());
    end
  endtask

  task automatic chk_row(input string tag, input logic [9:0] e);
    chk({tag, "_rdy"}, act[9], e[9]);
    chk({tag, "_out_valid"}, act[8], e[8]);
    chk({tag, "_error"}, act[7], e[7]);
    chk({tag, "_key_we"}, act[6], e[6]);
    chk({tag, "_key_sel"}, act[5:4], e[5:4]);
    chk({tag, "_key_loaded"}, act[3], e[3]);
    chk({tag, "_data_ld"}, act[2], e[2]);
    chk({tag, "_core_start"}, act[1], e[1]);
    chk({tag, "_out_ld"}, act[0], e[0]);
  endtask

  initial begin
    bus.key_config = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_rcvd = 1'b0;
    bus.core_done = 1'b0;
    // reset state
    tbl[0]  = '{5'b10000, 10'b1_0_0_0_00_0_0_0_0, 0};
    // three key words, key_loaded after the third
    tbl[1]  = '{5'b01100, 10'b1_0_0_1_00_0_0_0_0, 0};
    tbl[2]  = '{5'b01100, 10'b1_0_0_1_01_0_0_0_0, 0};
    tbl[3]  = '{5'b01100, 10'b1_0_0_1_10_0_0_0_0, 0};
    tbl[4]  = '{5'b01000, 10'b1_0_0_0_00_1_0_0_0, 0};
    // data word, core_done 5 cycles after core_start, then out_rcvd
    tbl[5]  = '{5'b00100, 10'b1_0_0_0_00_1_1_0_0, 6};
    tbl[6]  = '{5'b00000, 10'b0_0_0_0_00_1_0_1_0, 0};
    tbl[7]  = '{5'b00000, 10'b0_0_0_0_00_1_0_0_0, 0};
    tbl[8]  = '{5'b00000, 10'b0_0_0_0_00_1_0_0_0, 0};
    tbl[9]  = '{5'b00000, 10'b0_0_0_0_00_1_0_0_0, 0};
    tbl[10] = '{5'b00000, 10'b0_0_0_0_00_1_0_0_0, 0};
    tbl[11] = '{5'b00001, 10'b0_0_0_0_00_1_0_0_1, 0};
    tbl[12] = '{5'b00000, 10'b0_1_0_0_00_1_0_0_0, 0};
    tbl[13] = '{5'b00010, 10'b0_1_0_0_00_1_0_0_0, 0};
    tbl[14] = '{5'b00000, 10'b1_0_0_0_00_1_0_0_0, 0};
    // second data word, overrun while holding, out_rcvd and in_valid together
    tbl[15] = '{5'b00100, 10'b1_0_0_0_00_1_1_0_0, 3};
    tbl[16] = '{5'b00000, 10'b0_0_0_0_00_1_0_1_0, 0};
    tbl[17] = '{5'b00000, 10'b0_0_0_0_00_1_0_0_0, 0};
    tbl[18] = '{5'b00001, 10'b0_0_0_0_00_1_0_0_1, 0};
    tbl[19] = '{5'b00000, 10'b0_1_0_0_00_1_0_0_0, 0};
    tbl[20] = '{5'b00100, 10'b0_1_0_0_00_1_0_0_0, 0};
    tbl[21] = '{5'b00000, 10'b0_1_1_0_00_1_0_0_0, 0};
    tbl[22] = '{5'b00110, 10'b0_1_1_0_00_1_0_0_0, 0};
    tbl[23] = '{5'b00000, 10'b1_0_1_0_00_1_0_0_0, 0};
    // reset, partial key, then a dropped data word
    tbl[24] = '{5'b10000, 10'b1_0_1_0_00_1_0_0_0, 0};
    tbl[25] = '{5'b01100, 10'b1_0_0_1_00_0_0_0_0, 0};
    tbl[26] = '{5'b01100, 10'b1_0_0_1_01_0_0_0_0, 0};
    tbl[27] = '{5'b00000, 10'b1_0_0_0_10_0_0_0_0, 0};
    tbl[28] = '{5'b00100, 10'b1_0_1_0_00_0_0_0_0, 0};
    tbl[29] = '{5'b00000, 10'b1_0_1_0_00_0_0_0_0, 0};
    repeat (2) @(posedge clk);
    for (int i = 0; i < 30; i++) begin
      step(tbl[i].in);
      if (tbl[i].lat != 0) exp_q.push_back(cyc + tbl[i].lat);
      chk_row($sformatf("r%0d", i), tbl[i].ex);
    end
    // timeout: 64 BUSY cycles with no core_done
    step(5'b10000);
    repeat (3) step(5'b01100);
    step(5'b00000);
    chk("to_key_loaded", act[3], 1'b1);
    step(5'b00100);
    chk("to_data_ld", act[2], 1'b1);
    repeat (65) step(5'b00000);
    chk("to_last_busy_rdy", act[9], 1'b0);
    chk("to_last_busy_error", act[7], 1'b0);
    step(5'b00000);
    chk("to_rdy", act[9], 1'b1);
    chk("to_error", act[7], 1'b1);
    chk("to_out_valid", act[8], 1'b0);
    // reset mid-BUSY, then stray core_done/out_rcvd in IDLE
    step(5'b00100);
    chk("rb_data_ld", act[2], 1'b1);
    step(5'b00000);
    chk("rb_core_start", act[1], 1'b1);
    step(5'b00000);
    chk("rb_busy_rdy", act[9], 1'b0);
    step(5'b10000);
    step(5'b00000);
    chk("rb_key_loaded", act[3], 1'b0);
    chk("rb_out_valid", act[8], 1'b0);
    chk("rb_rdy", act[9], 1'b1);
    chk("rb_error", act[7], 1'b0);
    step(5'b00011);
    chk("stray_out_ld", act[0], 1'b0);
    step(5'b00000);
    chk("stray_out_valid", act[8], 1'b0);
    chk("stray_rdy", act[9], 1'b1);
    chk("stray_error", act[7], 1'b0);
    chk("sb_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
